mp_reg_file: RTL and testbench
==============================

MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 Parameter DWIDTH, 32, data width in bits.
REQ-002 Parameter DEPTH, 32, number of entries; power of two, at least 4.
REQ-003 Parameter NRD, 2, number of read ports, 1 to 4.
REQ-004 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 Parameter ZERO_REG, 1, 1 = entry 0 reads zero and ignores writes.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 clr_req  input  1  single-cycle request to zero the whole array.
REQ-009 ready  output  1  high when idle and accepting writes.
REQ-010 we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-011 wa0, wa1  input  log2(DEPTH) each  write addresses.
REQ-012 wd0, wd1  input  DWIDTH each  write data.
REQ-013 ra  input  NRD*log2(DEPTH)  packed read addresses, port k in slice k.
REQ-014 rd  output  NRD*DWIDTH  packed read data, port k in slice k.

Function
REQ-015 The array SHALL be distributed RAM with no reset, and reads SHALL be combinational from ra to rd.
REQ-016 The controller SHALL have two states, IDLE and CLEAR, and SHALL hold a sweep counter cnt of log2(DEPTH) bits.
REQ-017 In CLEAR, each rising edge SHALL write zero to entry cnt and increment cnt. The state SHALL move to IDLE on the edge that writes entry DEPTH-1.
REQ-018 The sweep SHALL start at cnt=1 when ZERO_REG=1, and at cnt=0 otherwise.
REQ-019 In IDLE, clr_req=1 SHALL move the state to CLEAR with cnt at its start value on the next edge. Writes presented in that same cycle SHALL still commit.
REQ-020 clr_req=1 during CLEAR SHALL restart the sweep at the start value.
REQ-021 ready SHALL be 1 exactly when the state is IDLE.
REQ-022 User writes SHALL commit only when ready=1. Writes presented while ready=0 SHALL be dropped silently.
REQ-023 When ZERO_REG=1, writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0 on every port.
REQ-024 When both write ports target the same address in the same cycle, port 1 SHALL win.
REQ-025 When BYPASS=1 and ready=1, a read port whose address matches an enabled, non-ignored write SHALL return that cycle's winning write data.
REQ-026 When BYPASS=0, reads SHALL return the stored value until the next edge.
REQ-027 While ready=0, every rd slice SHALL read 0.
REQ-028 All read ports SHALL be independent. Any ra combination, including duplicate addresses, SHALL be legal.

Reset
REQ-029 rst_n=0 SHALL immediately force state=CLEAR, cnt=start value and ready=0, so rd reads 0 during reset.
REQ-030 After rst_n rises, ready SHALL rise after DEPTH-1 edges (DEPTH edges if ZERO_REG=0). An rst_n assertion mid-sweep SHALL restart the sweep.

Structure
REQ-031 The state encoding (IDLE=0, CLEAR=1) and the address-width function SHALL live in the shared core package.
REQ-032 One sub-module, rf_bypass_mux, SHALL be instantiated once per read port. It SHALL implement zero-reg masking, ready masking and forwarding.

Verification
REQ-033 Defaults; release rst_n -> ready=0 for 31 edges and 1 after the 31st; reading every entry returns 0.
REQ-034 Write 0xDEADBEEF to entry 5 via port 0 and 0x12345678 to entry 5 via port 1 in the same cycle -> rd0 with ra0=5 shows 0x12345678 in that cycle (bypass) and after the edge.
REQ-035 Write 0xFFFFFFFF to entry 0 -> both ports read 0 forever; with ZERO_REG=0 the value reads back 0xFFFFFFFF.
REQ-036 Pulse clr_req with we0=1, wa0=7, wd0=0xA5 in the same cycle -> write commits, then is zeroed by the sweep; a write during the sweep is dropped and entry 9 reads 0 afterward.
REQ-037 Assert rst_n=0 at sweep edge 10 for 2 cycles -> ready stays 0 and rises 31 edges after release.
REQ-038 BYPASS=0, write 0x55 to entry 3 while ra1=3 -> rd1 shows the old value in that cycle and 0x55 after the edge.

Source files
------------

// File: rtl/mp_reg_file_pkg.sv
// Shared definitions for the multi-port register file.
//   rf_state_t : controller state encoding (IDLE=0, CLEAR=1)
//   addr_w()   : address width needed for a given entry count
package mp_reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // Floor of 1 keeps a degenerate depth from producing a zero-width bus.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Read-side output selection for one read port.
// Ports:
//   ra            : read address of this port
//   stored        : array contents at ra (combinational read)
//   ready         : controller idle; when low the port reads zero
//   wv0/wa0/wd0   : write port 0, enable already qualified (ready, zero-reg)
//   wv1/wa1/wd1   : write port 1, same qualification
//   rd            : read data
module rf_bypass_mux #(
  parameter int DWIDTH   = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]     ra,
  input  logic [DWIDTH-1:0] stored,
  input  logic              ready,
  input  logic              wv0,
  input  logic [AW-1:0]     wa0,
  input  logic [DWIDTH-1:0] wd0,
  input  logic              wv1,
  input  logic [AW-1:0]     wa1,
  input  logic [DWIDTH-1:0] wd1,
  output logic [DWIDTH-1:0] rd
);

  always_comb begin
    rd = stored;
    if (!ready) begin
      rd = '0;
    end else if (ZERO_REG != 0 && ra == '0) begin
      rd = '0;
    end else if (BYPASS != 0 && wv1 && wa1 == ra) begin
      // Port 1 is checked first so it wins a same-address collision,
      // matching what the array will hold after the edge.
      rd = wd1;
    end else if (BYPASS != 0 && wv0 && wa0 == ra) begin
      rd = wd0;
    end
  end

endmodule

// File: rtl/mp_reg_file.sv
// Two-write, NRD-read register file with a hardware clear sweep.
// Ports:
//   clk, rst_n       : clock (rising edge), async active-low reset
//   clr_req          : pulse to zero the whole array via the sweep
//   ready            : high when idle; user writes only commit then
//   we0/wa0/wd0      : write port 0
//   we1/wa1/wd1      : write port 1 (wins on address collision)
//   ra               : packed read addresses, port k in slice k
//   rd               : packed read data, port k in slice k
// The array itself has no reset; reset starts a sweep that writes zeros
// one entry per cycle, and reads are masked to zero until it completes.
module mp_reg_file
  import mp_reg_file_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa0,
  input  logic [AW-1:0]         wa1,
  input  logic [DWIDTH-1:0]     wd0,
  input  logic [DWIDTH-1:0]     wd1,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DWIDTH-1:0] rd
);

  // Entry 0 is hardwired to zero, so the sweep can skip it.
  localparam logic [AW-1:0] START = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  rf_state_t         state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wv0, wv1;

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= START;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = START;
        end
      end
      CLEAR: begin
        if (clr_req) begin
          cnt_nxt = START;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = START;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = START;
      end
    endcase
  end

  assign ready = (state == IDLE);

  // Qualified write enables: only while idle, never to the zero register.
  assign wv0 = we0 && ready && !(ZERO_REG != 0 && wa0 == '0);
  assign wv1 = we1 && ready && !(ZERO_REG != 0 && wa1 == '0);

  // ---------------- storage ----------------
  // No reset on the array so it maps onto distributed RAM. Port 1 is
  // written last so it takes precedence on a shared address.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (wv0) mem[wa0] <= wd0;
      if (wv1) mem[wa1] <= wd1;
    end
  end

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];

    rf_bypass_mux #(
      .DWIDTH  (DWIDTH),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .ra    (ra_k),
      .stored(mem[ra_k]),
      .ready (ready),
      .wv0   (wv0),
      .wa0   (wa0),
      .wd0   (wd0),
      .wv1   (wv1),
      .wa1   (wa1),
      .wd1   (wd1),
      .rd    (rd[k*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed bench for mp_reg_file. Three instances share the stimulus:
//   ua : defaults (BYPASS=1, ZERO_REG=1)
//   ub : ZERO_REG=0
//   uc : BYPASS=0
// Expected values go into a scoreboard queue as stimulus is applied and
// are popped when the corresponding output is sampled.
module tb_mp_reg_file;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_req = 1'b0;
  logic we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic [NRD*AW-1:0] ra = '0;
  logic ready_a, ready_b, ready_c;
  logic [NRD*DW-1:0] rd_a, rd_b, rd_c;

  always #5 clk = ~clk;

  mp_reg_file ua (.clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_a),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd_a));
  mp_reg_file #(.ZERO_REG(0)) ub (.clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .ready(ready_b), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0),
    .wd1(wd1), .ra(ra), .rd(rd_b));
  mp_reg_file #(.BYPASS(0)) uc (.clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .ready(ready_c), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0),
    .wd1(wd1), .ra(ra), .rd(rd_c));

  int total = 0;
  int passed = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, obs, e);
  endtask

  // Drive just after a rising edge; sample at the following falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    // ---- reset state ----
    #1 rst_n = 1'b0;
    set_ra(5'd3, 5'd17);
    #2;
    expect_val("reset_ready", 64'd0);
    observe(64'(ready_a));
    expect_val("reset_rd", 64'd0);
    observe(rd_a);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- initial sweep: ready rises after DEPTH-1 edges ----
    for (int i = 1; i <= DEPTH - 1; i++) begin
      tick();
      settle();
      expect_val($sformatf("sweep_ready_e%0d", i), (i >= DEPTH - 1) ? 64'd1 : 64'd0);
      observe(64'(ready_a));
    end
    expect_val("nozero_ready_e31", 64'd0);
    observe(64'(ready_b));
    tick();
    settle();
    expect_val("nozero_ready_e32", 64'd1);
    observe(64'(ready_b));

    // ---- every entry reads zero after reset ----
    for (int a = 0; a < DEPTH; a += 4) begin
      set_ra(AW'(a), AW'(DEPTH - 1 - a));
      #1;
      expect_val($sformatf("clean_rd_%0d", a), 64'd0);
      observe(rd_a);
    end

    // ---- dual write to entry 5, port 1 wins; port0-only bypass on 6 ----
    tick();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h12345678;
    set_ra(5'd5, 5'd5);
    settle();
    expect_val("collide_bypass", {32'h12345678, 32'h12345678});
    observe(rd_a);
    expect_val("collide_nobypass_old", 64'd0);
    observe(rd_c);
    tick();
    we1 = 1'b0;
    wa0 = 5'd6; wd0 = 32'h66;
    set_ra(5'd5, 5'd6);
    settle();
    expect_val("collide_stored_a", {32'h66, 32'h12345678});
    observe(rd_a);
    expect_val("collide_stored_c", {32'h0, 32'h12345678});
    observe(rd_c);

    // ---- entry 0 write ----
    tick();
    wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    set_ra(5'd0, 5'd0);
    settle();
    expect_val("zero_bypass_a", 64'd0);
    observe(rd_a);
    expect_val("zero_bypass_b", {32'hFFFFFFFF, 32'hFFFFFFFF});
    observe(rd_b);
    tick();
    we0 = 1'b0;
    settle();
    expect_val("zero_stored_a", 64'd0);
    observe(rd_a);
    expect_val("zero_stored_b", {32'hFFFFFFFF, 32'hFFFFFFFF});
    observe(rd_b);

    // ---- no-bypass instance: old value this cycle, new after the edge ----
    tick();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h55;
    set_ra(5'd6, 5'd3);
    settle();
    expect_val("nobyp_old", {32'h0, 32'h66});
    observe(rd_c);
    tick();
    we1 = 1'b0;
    settle();
    expect_val("nobyp_new", {32'h55, 32'h66});
    observe(rd_c);

    // ---- clear with coincident write; dropped write during sweep ----
    tick();
    clr_req = 1'b1;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5;
    tick();
    clr_req = 1'b0; we0 = 1'b0;
    set_ra(5'd5, 5'd3);
    settle();
    expect_val("clear_ready", 64'd0);
    observe(64'(ready_a));
    expect_val("clear_rd_masked", 64'd0);
    observe(rd_a);
    for (int i = 0; i < 15; i++) tick();
    // Sweep is past entry 9, so a committed write here would survive.
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    tick();
    we0 = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    settle();
    expect_val("clear_ready_e30", 64'd0);
    observe(64'(ready_a));
    tick();
    set_ra(5'd9, 5'd7);
    settle();
    expect_val("clear_ready_e31", 64'd1);
    observe(64'(ready_a));
    expect_val("clear_entries_9_7", 64'd0);
    observe(rd_a);
    set_ra(5'd5, 5'd3);
    #1;
    expect_val("clear_entries_5_3", 64'd0);
    observe(rd_a);
    tick();

    // ---- reset mid-sweep restarts it ----
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    settle();
    expect_val("midrst_ready", 64'd0);
    observe(64'(ready_a));
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH - 1; i++) begin
      tick();
      if (i >= DEPTH - 2) begin
        settle();
        expect_val($sformatf("midrst_ready_e%0d", i), (i >= DEPTH - 1) ? 64'd1 : 64'd0);
        observe(64'(ready_a));
      end
    end

    // ---- clr_req during CLEAR restarts the sweep ----
    tick();
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h2020;
    tick();
    we0 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i <= DEPTH - 1; i++) begin
      if (i >= DEPTH - 2) begin
        settle();
        expect_val($sformatf("restart_ready_e%0d", i - 1), (i - 1 >= DEPTH - 1) ? 64'd1 : 64'd0);
        observe(64'(ready_a));
      end
      tick();
    end
    set_ra(5'd20, 5'd0);
    settle();
    expect_val("restart_ready_done", 64'd1);
    observe(64'(ready_a));
    expect_val("restart_entry20", 64'd0);
    observe(rd_a);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule
